pxs_vga_source: RTL
===================

PXS_VGA_SOURCE -- requirements
Module: pxs_vga_source

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33, vertical porches and sync width in lines.
REQ-007 px_clk  input  1  pixel clock, the single clock; all logic SHALL be rising-edge clocked.
REQ-008 px_rst  input  1  asynchronous, active-high reset.
REQ-009 en  input  1  pixel tick; the counters and the stream SHALL advance only in cycles with en=1.
REQ-010 VGAStr_o  output  23  VGA stream without RGB: [0] ActiveVideo, [1] VSync, [2] HSync, [12:3] YCoord, [22:13] XCoord.
REQ-011 frame_o  output  1  one-cycle pulse issued when the first pixel (0,0) of a frame is presented.

Function
REQ-012 The block SHALL hold a horizontal counter hc and a vertical counter vc, each 10 bits wide.
REQ-013 hc SHALL cover 0..HT-1, where HT = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
REQ-014 vc SHALL cover 0..VT-1, where VT = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
REQ-015 On an en cycle, hc SHALL increment; at hc=HT-1 it SHALL wrap to 0 and vc SHALL increment in the same cycle.
REQ-016 At hc=HT-1 and vc=VT-1 together, both counters SHALL wrap to 0 in the same cycle.
REQ-017 VGAStr_o SHALL be registered and SHALL reflect the counter state from before the en edge, so latency is 1 en cycle and all fields come from the same (hc,vc).
REQ-018 XCoord SHALL equal hc and YCoord SHALL equal vc, including during blanking; the coordinates are raw and not clamped.
REQ-019 ActiveVideo SHALL be 1 if and only if hc<H_ACTIVE and vc<V_ACTIVE.
REQ-020 HSync SHALL be 0 (active-low) if and only if H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; by default that is hc 656..751.
REQ-021 VSync SHALL be 0 (active-low) if and only if V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC; by default that is vc 490..491.
REQ-022 frame_o SHALL be 1 for exactly the en cycle in which VGAStr_o is loaded with hc=0, vc=0, and 0 in every other cycle.
REQ-023 In a cycle with en=0, the counters, VGAStr_o and frame_o SHALL hold their values, except that frame_o SHALL be 0.
REQ-024 Parameter sets whose HT or VT exceeds 1024 SHALL be rejected at elaboration.

Reset
REQ-025 While px_rst=1: hc=0, vc=0, VGAStr_o = 23'h000006 (coordinates 0, both syncs inactive high, ActiveVideo 0), frame_o=0.
REQ-026 When reset is asserted mid-frame, it SHALL take effect immediately and asynchronously; after release, the first en cycle SHALL present (0,0) with frame_o=1.

Configuration
REQ-027 With PXS_FRAME_CNT_EN defined, the block SHALL add output frame_cnt_o (8 bits).
REQ-028 frame_cnt_o SHALL reset to 0, SHALL increment on every en cycle in which vc wraps from VT-1 to 0, and SHALL wrap from 255 to 0.
REQ-029 Without PXS_FRAME_CNT_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 The shared package pxs_pkg SHALL hold the stream field positions (ActiveVideo, VSync, HSync, YCoord, XCoord, RGB 25:23), the stream widths 23 and 26, and the default 640x480 timing constants.
REQ-031 Sub-module pxs_timing_counter SHALL be a modulo-N counter with enable input and wrap-pulse output; it SHALL be instantiated twice, horizontal and vertical, with the vertical instance enabled by the horizontal wrap pulse.

Verification
REQ-032 Reset with en=1 held: first output (0,0) with ActiveVideo=1 and frame_o=1; next output (1,0).
REQ-033 Run one line: ActiveVideo falls at X=640; HSync low for X=656..751 (96 cycles); X=799 is followed by (0,1).
REQ-034 Run one full frame: VSync low for Y=490..491 (1600 en cycles); the 420000th en cycle after a frame_o pulse carries the next frame_o pulse.
REQ-035 en toggled 1,0,0,1: the output advances by exactly 2 pixels and frame_o is never high in an en=0 cycle.
REQ-036 Assert px_rst at (300,200) between clock edges: the output becomes 23'h000006 with no clock edge, and restart is at (0,0).
REQ-037 With PXS_FRAME_CNT_EN defined, run 257 frames: frame_cnt_o reads 1 after the wrap through 255.

Source files
------------

// File: rtl/pxs_pkg.sv
// Shared definitions for the pixel stream: field positions, stream widths and default 640x480 timing.
package pxs_pkg;

  localparam int unsigned STR_W     = 23;
  localparam int unsigned STR_RGB_W = 26;
  localparam int unsigned COORD_W   = 10;

  localparam int unsigned AV_BIT  = 0;
  localparam int unsigned VS_BIT  = 1;
  localparam int unsigned HS_BIT  = 2;
  localparam int unsigned Y_LSB   = 3;
  localparam int unsigned Y_MSB   = 12;
  localparam int unsigned X_LSB   = 13;
  localparam int unsigned X_MSB   = 22;
  localparam int unsigned RGB_LSB = 23;
  localparam int unsigned RGB_MSB = 25;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Idle stream: origin coordinates, both syncs at their inactive high level, no active video.
  localparam logic [STR_W-1:0] STR_RESET = 23'h000006;

  function automatic logic [STR_W-1:0] packStream(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic               hSync,
    input logic               vSync,
    input logic               activeVideo
  );
    logic [STR_W-1:0] s;
    s                = '0;
    s[X_MSB:X_LSB]   = x;
    s[Y_MSB:Y_LSB]   = y;
    s[HS_BIT]        = hSync;
    s[VS_BIT]        = vSync;
    s[AV_BIT]        = activeVideo;
    return s;
  endfunction

endpackage

// File: rtl/pxs_timing_counter.sv
// Modulo-N counter with enable; wrap_o flags the enabled cycle in which the count returns to zero.
module pxs_timing_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    wrap_o  = en_i && (count_q == W'(N - 1));
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pxs_vga_source.sv
// VGA timing source emitting a registered RGB-less pixel stream and a frame-start pulse.
// Optional feature: define PXS_FRAME_CNT_EN to add the 8-bit frame_cnt_o output.
module pxs_vga_source
  import pxs_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             px_clk,
  input  logic             px_rst,
  input  logic             en,
  output logic [STR_W-1:0] VGAStr_o,
  output logic             frame_o
`ifdef PXS_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt_o
`endif
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Compare thresholds are one bit wider than the counters so a limit of exactly 1024 stays exact.
  localparam logic [COORD_W:0] H_ACT_END  = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0] H_SYNC_BEG = (COORD_W+1)'(H_ACTIVE + H_FP);
  localparam logic [COORD_W:0] H_SYNC_END = (COORD_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W:0] V_ACT_END  = (COORD_W+1)'(V_ACTIVE);
  localparam logic [COORD_W:0] V_SYNC_BEG = (COORD_W+1)'(V_ACTIVE + V_FP);
  localparam logic [COORD_W:0] V_SYNC_END = (COORD_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (HT > 1024 || VT > 1024) begin : g_bad_timing
    $error("pxs_vga_source: HT=%0d VT=%0d exceed the 10-bit counter range", HT, VT);
  end

  logic [COORD_W-1:0] hCount;
  logic [COORD_W-1:0] vCount;
  logic               hWrap;
  logic               vWrap;

  pxs_timing_counter #(.N(HT), .W(COORD_W)) u_hcnt (
    .clock_i (px_clk),
    .reset_i (px_rst),
    .en_i    (en),
    .count_o (hCount),
    .wrap_o  (hWrap)
  );

  // The vertical counter only steps on the last pixel of a line.
  pxs_timing_counter #(.N(VT), .W(COORD_W)) u_vcnt (
    .clock_i (px_clk),
    .reset_i (px_rst),
    .en_i    (hWrap),
    .count_o (vCount),
    .wrap_o  (vWrap)
  );

  logic [COORD_W:0] hExt;
  logic [COORD_W:0] vExt;
  logic             hSyncN;
  logic             vSyncN;
  logic             activeVideo;
  logic [STR_W-1:0] stream_d;
  logic [STR_W-1:0] stream_q;
  logic             frame_q;

  always_comb begin
    hExt        = {1'b0, hCount};
    vExt        = {1'b0, vCount};
    activeVideo = (hExt < H_ACT_END) && (vExt < V_ACT_END);
    hSyncN      = !((hExt >= H_SYNC_BEG) && (hExt < H_SYNC_END));
    vSyncN      = !((vExt >= V_SYNC_BEG) && (vExt < V_SYNC_END));
    stream_d    = packStream(hCount, vCount, hSyncN, vSyncN, activeVideo);
  end

  // The stream shows the position the counters held before this tick, so every field shares one (hc,vc).
  always_ff @(posedge px_clk or posedge px_rst) begin
    if (px_rst) begin
      stream_q <= STR_RESET;
      frame_q  <= 1'b0;
    end else begin
      frame_q <= en && (hCount == '0) && (vCount == '0);
      if (en) begin
        stream_q <= stream_d;
      end
    end
  end

  assign VGAStr_o = stream_q;
  assign frame_o  = frame_q;

`ifdef PXS_FRAME_CNT_EN
  logic [7:0] frameCnt_q;

  always_ff @(posedge px_clk or posedge px_rst) begin
    if (px_rst) begin
      frameCnt_q <= 8'd0;
    end else if (vWrap) begin
      frameCnt_q <= frameCnt_q + 8'd1;
    end
  end

  assign frame_cnt_o = frameCnt_q;
`else
  logic unusedVWrap;
  assign unusedVWrap = vWrap;
`endif

endmodule
